// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : serial_adder_pkg

// File: rtl/fa_cell.sv
// Single-bit combinational full adder; the only arithmetic cell in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule : fa_cell

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice per clock, LSB first,
// with registered sum, carry-out and signed-overflow results.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic [WIDTH-1:0]   res_sr_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fa_s;
    logic               fa_co;
    logic               last_bit_c;
    logic               accept_c;

    assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept_c   = (state_q == IDLE) && start;

    fa_cell u_fa (
        .a  (op_a_q[0]),
        .b  (op_b_q[0]),
        .c  (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; terminal count forces DONE so the counter never wraps
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they track state_q exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= (state_d == IDLE);
            busy  <= (state_d != IDLE);
            done  <= (state_d == DONE);
        end
    end

    // Operand capture and per-bit shift datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (accept_c) begin
            op_a_q   <= a;
            op_b_q   <= (sub == MODE_SUB) ? ~b : b;
            carry_q  <= (sub == MODE_SUB) ? ~cin : cin;
            res_sr_q <= '0;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            op_a_q   <= op_a_q >> 1;
            op_b_q   <= op_b_q >> 1;
            res_sr_q <= {fa_s, res_sr_q[WIDTH-1:1]};
            carry_q  <= fa_co;
            if (!last_bit_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Result registers load only on the final RUN edge; carry_q is then the MSB carry-in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if ((state_q == RUN) && last_bit_c) begin
            sum  <= {fa_s, res_sr_q[WIDTH-1:1]};
            cout <= fa_co;
            ovf  <= carry_q ^ fa_co;
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed/random ops and
// exhaustive WIDTH=4 ops, checked against an arithmetic reference model.
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst8_n = 1'b0;
    logic       rst4_n = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ready8, busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       ready4, busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    exp_t q8[$];
    exp_t q4[$];
    int   done_cyc8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values; returns {ovf, cout, sum}
    function automatic logic [9:0] model(input int w, input logic sub, input int a,
                                         input int b, input logic cin);
        int lim  = 1 << w;
        int half = 1 << (w - 1);
        int full, sa, sb, sres, s;
        logic co, ov;
        if (!sub) begin
            full = a + b + int'(cin);
            co   = (full >= lim);
        end else begin
            full = a - b - int'(cin);
            co   = (full >= 0);
        end
        sa   = (a >= half) ? a - lim : a;
        sb   = (b >= half) ? b - lim : b;
        sres = sub ? sa - sb - int'(cin) : sa + sb + int'(cin);
        ov   = (sres < -half) || (sres >= half);
        s    = ((full % lim) + lim) % lim;
        return {ov, co, 8'(s)};
    endfunction

    // Monitors: pop expected results whenever a done pulse is presented
    always @(negedge clk) begin
        if (rst8_n && done8) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w8_unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8_sum", sum8, e.sum);
                chk("w8_cout", cout8, e.cout);
                chk("w8_ovf", ovf8, e.ovf);
                chk("w8_latency", cyc - e.acc, 8);
                chk("w8_busy_at_done", {ready8, busy8}, 2'b01);
                done_cyc8.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst4_n && done4) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w4_unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("w4_sum", sum4, e.sum[3:0]);
                chk("w4_cout", cout4, e.cout);
                chk("w4_ovf", ovf4, e.ovf);
                chk("w4_latency", cyc - e.acc, 4);
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, input bit hold);
        logic [9:0] r;
        exp_t e;
        int n = 0;
        r = model(8, sub, int'(a), int'(b), cin);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
        while (!ready8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("w8_ready_timeout", 0, 1);
        e.sum = r[7:0]; e.cout = r[8]; e.ovf = r[9]; e.acc = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        if (!hold) start8 = 1'b0;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic sub);
        logic [9:0] r;
        exp_t e;
        int n = 0;
        r = model(4, sub, int'(a), int'(b), cin);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = cin; sub4 = sub; start4 = 1'b1;
        while (!ready4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("w4_ready_timeout", 0, 1);
        e.sum = r[7:0]; e.cout = r[8]; e.ovf = r[9]; e.acc = cyc + 1;
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("w8_drain", q8.size(), 0);
    endtask

    task automatic run_w8();
        // Directed arithmetic corners
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        drain8();
        op8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        drain8();
        op8(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        drain8();
        op8(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
        drain8();

        // Mid-RUN reset: result registers still hold the last (nonzero) result here
        op8(8'h3C, 8'h5A, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst8_n = 1'b0;
        void'(q8.pop_back());
        #1;
        chk("rst_mid_sum", sum8, 0);
        chk("rst_mid_flags", {cout8, ovf8, done8}, 3'b000);
        chk("rst_mid_hs", {ready8, busy8}, 2'b10);
        @(negedge clk);
        rst8_n = 1'b1;
        repeat (12) @(negedge clk);
        op8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        drain8();

        // start during RUN is ignored
        op8(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sub8 = 1'b1;
        repeat (3) @(negedge clk);
        start8 = 1'b0;
        drain8();

        // Held start: back-to-back ops spaced WIDTH+2 cycles
        op8(8'h0F, 8'hF0, 1'b1, 1'b0, 1'b1);
        op8(8'h99, 8'h66, 1'b0, 1'b1, 1'b0);
        drain8();
        if (done_cyc8.size() >= 2)
            chk("w8_b2b_spacing", done_cyc8[done_cyc8.size()-1] - done_cyc8[done_cyc8.size()-2], 10);
        else
            chk("w8_b2b_done_count", done_cyc8.size(), 2);

        for (int i = 0; i < 150; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        drain8();
    endtask

    task automatic run_w4();
        int n = 0;
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++)
                        op4(4'(x), 4'(y), 1'(c), 1'(s));
        while (q4.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("w4_drain", q4.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sum8", sum8, 0);
        chk("rst_flags8", {cout8, ovf8, done8}, 3'b000);
        chk("rst_hs8", {ready8, busy8}, 2'b10);
        chk("rst_hs4", {ready4, busy4, done4}, 3'b100);
        @(negedge clk);
        rst8_n = 1'b1;
        rst4_n = 1'b1;
        fork
            run_w8();
            run_w4();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_adder
